// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial A - B - bin engine: one full-subtraction bit per clock, LSB first.
// A three-state controller (IDLE -> SHIFT -> DONE) loads the operands, walks
// them through a single one-bit subtract stage and publishes diff/bout with a
// one-cycle done pulse.
// Optional build macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   // The A register doubles as the result accumulator: each difference bit
   // enters at the MSB as the consumed minuend bit leaves at the LSB.
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_brw;
   logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_am;
   logic             r_bm;
`endif

   logic             w_a0;
   logic             w_b0;
   logic             w_d;
   logic             w_nb;
   logic             w_last;
   logic [WIDTH-1:0] w_res;

   // One-bit full subtractor on the current LSBs plus the running borrow
   assign w_a0   = r_a[0];
   assign w_b0   = r_b[0];
   assign w_d    = w_a0 ^ w_b0 ^ r_brw;
   assign w_nb   = (~w_a0 & w_b0) | (~w_a0 & r_brw) | (w_b0 & r_brw);
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_res  = {w_d, r_a[WIDTH-1:1]};

   // Controller FSM with registered outputs; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_brw   <= 1'b0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_am    <= 1'b0;
         r_bm    <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_brw   <= bin;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  r_am    <= a[WIDTH-1];
                  r_bm    <= b[WIDTH-1];
`endif
               end
            end

            S_SHIFT: begin
               r_a   <= w_res;
               r_b   <= {1'b0, r_b[WIDTH-1:1]};
               r_brw <= w_nb;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  // Final bit: publish on the same edge that raises done
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  diff    <= w_res;
                  bout    <= w_nb;
                  r_state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf     <= (r_am ^ r_bm) & (r_am ^ w_d);
`endif
               end
            end

            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl
// Directed-vector bench for serial_subtractor_ctrl (WIDTH=8). Expected values
// are hand-computed constants. Define SERIAL_SUB_OVF_EN to also cover ovf.
module tb_serial_subtractor_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] prev_diff = 8'h00;

   serial_subtractor_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports mismatches
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one operation and check busy length, latency, result and pulse width
   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ibin, input logic [7:0] ed, input logic eb,
                         input logic eo);
      int busy_cnt;
      int lat;
      bit got;
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " diff held"}, diff, prev_diff);
      busy_cnt = 0; lat = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (busy) busy_cnt++;
         if (done) begin
            got = 1;
            lat = i;
         end else begin
            @(negedge clk);
         end
      end
      chk({tag, " done seen"}, got, 1);
      chk({tag, " busy cycles"}, busy_cnt, 8);
      chk({tag, " latency"}, lat, 8);
      chk({tag, " diff"}, diff, ed);
      chk({tag, " bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, " ovf"}, ovf, eo);
`else
      if (eo === 1'bx) $display("note: unexpected x expectation");
`endif
      prev_diff = ed;
      @(negedge clk);
      chk({tag, " done single"}, done, 0);
      chk({tag, " diff hold"}, diff, ed);
   endtask

   initial begin
      int ndone;
      int t_first;
      int t_last;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #12;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst diff", diff, 0);
      chk("rst bout", bout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic vectors
      run_op("5A-3C", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
      run_op("00-01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("10-0F-1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
      run_op("FF-FF-1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // start held high: back-to-back operations, operands disturbed mid-SHIFT
      @(negedge clk);
      a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
      ndone = 0; t_first = -1; t_last = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (t_first < 0) t_first = i;
            t_last = i;
            chk("held diff", diff, 8'h1B);
            chk("held bout", bout, 0);
            a = 8'h20; b = 8'h05;
         end else if (busy) begin
            a = 8'hC3; b = 8'h77;
         end
      end
      start = 1'b0;
      a = 8'h20; b = 8'h05;
      chk("held done count", ndone, 3);
      chk("held first", t_first, 8);
      chk("held period", t_last - t_first, 20);
      prev_diff = 8'h1B;
      repeat (3) @(negedge clk);

      // start pulse while busy is ignored
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin
            a = 8'h01; b = 8'h02; bin = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            chk("ignore diff", diff, 8'h1E);
            chk("ignore bout", bout, 0);
         end
         @(negedge clk);
      end
      chk("ignore done count", ndone, 1);
      prev_diff = 8'h1E;

      // Leave a nonzero result so the async clear is visible
      run_op("00-01 b", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

      // Async reset mid-SHIFT aborts the operation
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre-rst busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async busy", busy, 0);
      chk("async done", done, 0);
      chk("async diff", diff, 0);
      chk("async bout", bout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort no done", ndone, 0);
      prev_diff = 8'h00;
      run_op("post-rst", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
      run_op("ovf 80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("ovf 05-03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Bit-serial subtraction engine: computes A - B - bin one bit per clock, LSB first, through a single one-bit full-subtraction stage.
- The controller sequences that stage: loads operands, shifts them through, carries the borrow in a flop between bits, and assembles the result word.
- Used where area matters more than latency; sits between a requester issuing start/operands and a consumer reading the result on done.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
CNT_W, $clog2(WIDTH), width of the internal bit counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a subtraction; sampled only in IDLE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  initial borrow-in, captured on accepted start
busy  output  1  high while a subtraction is in progress (SHIFT state)
done  output  1  single-cycle pulse when diff/bout are valid
diff  output  WIDTH  result A - B - bin, modulo 2^WIDTH
bout  output  1  final borrow out; 1 iff A < B + bin (unsigned)

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Operand shift registers, borrow flop and counter are all cleared.
- States:
  - IDLE: busy=0. If start=1, capture a, b and bin into the A-shift register, B-shift register and borrow flop; clear the counter; go to SHIFT.
  - SHIFT: busy=1. Each cycle, take d = a0^b0^brw and nb = (~a0&b0)|(~a0&brw)|(b0&brw), where a0/b0 are the LSBs of the shift registers and brw is the borrow flop. Shift d into the result register MSB-side (right shift), so that after WIDTH shifts bit i is in position i. Right-shift the A/B registers, set brw=nb, and increment the counter. On the cycle where counter==WIDTH-1, go to DONE.
  - DONE: busy=0. Pulse done=1 for exactly one cycle; diff/bout update on the same edge that raises done. Return to IDLE.
- Latency: start sampled at edge N; done high in the cycle after edge N+WIDTH; the earliest next start is accepted at edge N+WIDTH+2.
- diff and bout hold their values until the next done; they are not cleared on a new start.
- start while busy or in DONE is ignored: no queuing, no effect on the operation in flight.
- Operands are captured on start only; changes to a, b or bin during SHIFT have no effect.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no done is generated.
- Arithmetic: unsigned modulo 2^WIDTH. bout equals the borrow out of the MSB stage.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0), updated with diff on done.
  - ovf = two's-complement signed overflow of A - B - bin = (aM ^ bM) & (aM ^ dM), where aM and bM are the captured operand MSBs and dM is the result MSB.
  - Requires the captured MSBs of a and b to be retained until the final bit.
- When not defined: no ovf port, no extra logic; all other behaviour identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> busy high 8 cycles, then done pulse with diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- start held high continuously with a=0x20, b=0x05 -> done pulse every 10 cycles with diff=0x1B each time; operands changed mid-SHIFT do not alter the result.
- Pulse start again 3 cycles into SHIFT with different operands -> ignored; first result delivered unchanged; exactly one done.
- Assert rst_n=0 mid-SHIFT -> busy, done, diff and bout go to 0 asynchronously, no done pulse; after release, a new start completes normally.
- With SERIAL_SUB_OVF_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
  - a=0x05, b=0x03 -> ovf=0.
